alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Driving side of the ALU_J interface. Accepts one instruction at a time over a
//  valid/ready handshake and reads operands from an internal register bank.
//  Drives opcode/operand1/operand2/param into ALU_J, captures result and status,
//  then writes back to the bank and to a sticky flags register.
//  Sits between the instruction decoder and ALU_J in the Jac1-8 datapath.
// PARAMETERS
//  DataWidth      8  operand/result width
//  NumOpCodeBits  5  ALU opcode width
//  ParamBits      8  shift amount / immediate width
//  NumStatusBits  6  ALU status width: 0 carry, 1 underflow, 2 zero, 3 equal, 4 gt, 5 lt
//  NumRegs        4  register bank depth; index width RegBits = $clog2(NumRegs) = 2
// PORTS
//  clk           in   1          single clock, rising edge
//  rst_n         in   1          asynchronous, active-low reset
//  instr_valid   in   1          instruction offered
//  instr_ready   out  1          controller can accept (IDLE only)
//  instr_opcode  in   5          ALU opcode (Op_NOP..Op_VAL = 0..9)
//  instr_rd      in   RegBits    destination reg; also operand1 source
//  instr_rs      in   RegBits    operand2 source reg
//  instr_param   in   ParamBits  shift amount / immediate for Op_VAL
//  alu_opcode    out  5          to ALU_J.opcode
//  alu_operand1  out  DataWidth  to ALU_J.operand1
//  alu_operand2  out  DataWidth  to ALU_J.operand2
//  alu_param     out  ParamBits  to ALU_J.param
//  alu_result    in   DataWidth  from ALU_J.result (combinational)
//  alu_status    in   6          from ALU_J.status (combinational)
//  done          out  1          1-cycle pulse: instruction retired
//  illegal       out  1          1-cycle pulse together with done: opcode > 9
//  result_out    out  DataWidth  captured result; valid while done=1
//  flags         out  6          architectural status register
//  dbg_sel       in   RegBits    register bank debug select
//  dbg_data      out  DataWidth  bank[dbg_sel], combinational read
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; bank, flags, result_out and all alu_* outputs are 0;
//    instr_ready=1 after release; done=0, illegal=0.
//  - FSM: IDLE -> READ -> EXEC -> WB -> IDLE. All transitions are unconditional except in IDLE.
//  - IDLE: instr_ready=1. On instr_valid&&instr_ready at edge T, latch opcode/rd/rs/param
//    and go to READ. Otherwise stay in IDLE.
//  - READ (T+1): op1_q <= bank[rd], op2_q <= bank[rs].
//  - EXEC (T+2): alu_* driven from the latched registers. At the closing edge, res_q <= alu_result
//    and stat_q <= alu_status.
//  - WB (T+3): done=1 and result_out=res_q. At the closing edge, write bank[rd] <= res_q and
//    flags <= stat_q. New values are visible on dbg_data/flags at T+4.
//  - Latency is 4 cycles from acceptance to write-back. Peak throughput is 1 instruction per 4 cycles.
//  - instr_ready=0 in READ/EXEC/WB. instr_valid in those states is ignored, not queued.
//  - In all states except EXEC, alu_opcode=Op_NOP and alu_operand1/operand2/param=0.
//  - Op_NOP: walks the FSM and pulses done. No bank write; flags unchanged.
//  - Op_VAL: bank[rd] <= ALU_J result (param load); flags <= ALU_J status, as for any other op.
//  - Opcode > 9: FSM walks normally; done and illegal pulse in WB. No bank write; flags unchanged.
//  - rd==rs is legal: both operands read the same pre-write value.
//  - Width rules: no arithmetic inside this block. Carry/underflow come only from ALU_J.
//  - Reset asserted mid-operation: immediate abort. No write-back, no done pulse; the bank is cleared.
// TESTING (bench instantiates alu_issue_ctrl + ALU_J)
//  1. VAL r0<=1, VAL r1<=3, ADD rd=0,rs=1 -> done at T+3; r0=4; flags=6'b100000 (lt).
//  2. VAL r2<=255, VAL r3<=2, ADD rd=2,rs=3 -> r2=1; flags=6'b010001 (carry, gt).
//  3. VAL r0<=14, VAL r1<=15, SUB rd=0,rs=1 -> r0=255; flags=6'b100010 (underflow, lt).
//  4. instr_valid held high with 3 queued ops -> accepted at cycles 0,4,8; instr_ready low otherwise;
//     alu_opcode=0 outside EXEC.
//  5. opcode 5'b1_0000 -> done=illegal=1 for one cycle; bank and flags unchanged.
//  6. rst_n low during EXEC of ADD -> outputs 0 immediately; r0 unchanged(0); no done; ready after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller on the driving side of ALU_J: accepts one instruction, reads the
// register bank, drives ALU_J for one cycle, then writes the result and status back.
module alu_issue_ctrl #(
    parameter int DataWidth     = 8,
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int NumStatusBits = 6,
    parameter int NumRegs       = 4,
    localparam int RegBits      = $clog2(NumRegs)
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [NumOpCodeBits-1:0] instr_opcode,
    input  logic [RegBits-1:0]       instr_rd,
    input  logic [RegBits-1:0]       instr_rs,
    input  logic [ParamBits-1:0]     instr_param,

    output logic [NumOpCodeBits-1:0] alu_opcode,
    output logic [DataWidth-1:0]     alu_operand1,
    output logic [DataWidth-1:0]     alu_operand2,
    output logic [ParamBits-1:0]     alu_param,
    input  logic [DataWidth-1:0]     alu_result,
    input  logic [NumStatusBits-1:0] alu_status,

    output logic                     done,
    output logic                     illegal,
    output logic [DataWidth-1:0]     result_out,
    output logic [NumStatusBits-1:0] flags,

    input  logic [RegBits-1:0]       dbg_sel,
    output logic [DataWidth-1:0]     dbg_data
);

    localparam logic [NumOpCodeBits-1:0] OpNop = NumOpCodeBits'(0);
    localparam logic [NumOpCodeBits-1:0] OpVal = NumOpCodeBits'(9);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t state, state_next;

    logic [NumOpCodeBits-1:0] op_q;
    logic [RegBits-1:0]       rd_q;
    logic [RegBits-1:0]       rs_q;
    logic [ParamBits-1:0]     param_q;
    logic [DataWidth-1:0]     op1_q;
    logic [DataWidth-1:0]     op2_q;
    logic [DataWidth-1:0]     res_q;
    logic [NumStatusBits-1:0] stat_q;
    logic [NumStatusBits-1:0] flags_q;
    logic [DataWidth-1:0]     bank [NumRegs];

    logic accept;
    logic op_illegal;
    logic op_writes_back;

    assign accept         = instr_valid && instr_ready;
    assign op_illegal     = (op_q > OpVal);
    // NOP and out-of-range opcodes retire without touching architectural state.
    assign op_writes_back = (op_q != OpNop) && !op_illegal;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_READ;
            S_READ:  state_next = S_EXEC;
            S_EXEC:  state_next = S_WB;
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: the register bank is reset explicitly because an abort must leave
    // it cleared; without this a reset would not make it a plain RAM either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            param_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            stat_q  <= '0;
            flags_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                bank[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= instr_opcode;
                        rd_q    <= instr_rd;
                        rs_q    <= instr_rs;
                        param_q <= instr_param;
                    end
                end
                S_READ: begin
                    op1_q <= bank[rd_q];
                    op2_q <= bank[rs_q];
                end
                S_EXEC: begin
                    res_q  <= alu_result;
                    stat_q <= alu_status;
                end
                S_WB: begin
                    if (op_writes_back) begin
                        bank[rd_q] <= res_q;
                        flags_q    <= stat_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        instr_ready  = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        alu_opcode   = OpNop;
        alu_operand1 = '0;
        alu_operand2 = '0;
        alu_param    = '0;
        case (state)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                alu_opcode   = op_q;
                alu_operand1 = op1_q;
                alu_operand2 = op2_q;
                alu_param    = param_q;
            end
            S_WB: begin
                done    = 1'b1;
                illegal = op_illegal;
            end
            default: ;
        endcase
    end

    assign result_out = res_q;
    assign flags      = flags_q;
    assign dbg_data   = bank[dbg_sel];

endmodule
